// File: rtl/dm_ctrl_if.sv
// Request/response bus between the MEM stage and the data memory controller.
interface dm_ctrl_if #(
    parameter int AddrWidth = 14
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [1:0]           req_size;
    logic                 req_unsigned;
    logic [AddrWidth-1:0] req_addr;
    logic [31:0]          req_wdata;
    logic                 rsp_valid;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_ctrl.sv
// Byte-addressed data memory with sized/extended loads, configurable response
// latency and a sequential post-reset clear that holds off requests.

module dm_lane #(
    parameter int Words = 16,
    parameter int IdxW  = 4
) (
    input  logic            clk,
    input  logic            we,
    input  logic [IdxW-1:0] idx,
    input  logic [7:0]      wdata,
    output logic [7:0]      rdata
);
    logic [7:0] mem [Words];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    // Asynchronous read so a store at one edge is seen by a load at the next.
    assign rdata = mem[idx];
endmodule

module dm_ctrl #(
    parameter int AddrWidth   = 14,
    parameter int ReadLatency = 1
) (
    input logic    clk,
    input logic    rst,
    dm_ctrl_if.slave bus
);
    localparam int IdxW      = AddrWidth - 2;
    localparam int MemWords  = 1 << IdxW;
    localparam int NUM_LANES = 4;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state, state_nxt;
    logic [IdxW-1:0] clr_cnt, clr_nxt;
    logic            clr_we;
    logic            ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clr_nxt   = clr_cnt;
        clr_we    = 1'b0;
        ready     = 1'b0;
        case (state)
            CLEAR: begin
                clr_we  = !rst;
                clr_nxt = clr_cnt + 1'b1;
                if (clr_cnt == IdxW'(MemWords - 1)) state_nxt = RUN;
            end
            RUN: ready = !rst;
        endcase
    end

    assign bus.req_ready = ready;

    logic [1:0]      lane;
    logic [IdxW-1:0] widx;
    logic            err, accept, st_en;
    logic [3:0]      be;
    logic [31:0]     wrep;

    assign lane   = bus.req_addr[1:0];
    assign widx   = bus.req_addr[AddrWidth-1:2];
    assign accept = bus.req_valid && ready;
    assign st_en  = accept && bus.req_write && !err;

    always_comb begin
        err  = 1'b0;
        be   = 4'b1111;
        wrep = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                be   = 4'b0001 << lane;
                wrep = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                err  = lane[0];
                be   = 4'b0011 << lane;
                wrep = {2{bus.req_wdata[15:0]}};
            end
            2'b10: err = (lane != 2'b00);
            default: err = 1'b1;
        endcase
    end

    logic [NUM_LANES-1:0]          lane_we;
    logic [NUM_LANES-1:0][7:0]     lane_wdata;
    logic [NUM_LANES-1:0][7:0]     lane_rdata;
    logic [IdxW-1:0]               mem_idx;

    assign mem_idx = clr_we ? clr_cnt : widx;

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_we[i]    = clr_we || (st_en && be[i]);
            lane_wdata[i] = clr_we ? 8'h00 : wrep[8*i +: 8];
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        dm_lane #(.Words(MemWords), .IdxW(IdxW)) u_lane (
            .clk   (clk),
            .we    (lane_we[g]),
            .idx   (mem_idx),
            .wdata (lane_wdata[g]),
            .rdata (lane_rdata[g])
        );
    end

    logic [31:0] rword, ld_data, rd0;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        er0;

    assign rword   = lane_rdata;
    assign ld_byte = rword[{lane, 3'b000} +: 8];
    assign ld_half = rword[{lane[1], 4'b0000} +: 16];

    always_comb begin
        case (bus.req_size)
            2'b00:   ld_data = bus.req_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = bus.req_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = rword;
        endcase
    end

    // Stores and errors carry zero data, so rsp_rdata is only non-zero for good loads.
    assign rd0 = (accept && !bus.req_write && !err) ? ld_data : 32'h0;
    assign er0 = accept && err;

    logic [ReadLatency:1]        vld_pipe, err_pipe;
    logic [ReadLatency:1][31:0]  rd_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            err_pipe <= '0;
            rd_pipe  <= '0;
        end else begin
            vld_pipe[1] <= accept;
            err_pipe[1] <= er0;
            rd_pipe[1]  <= rd0;
            for (int i = 2; i <= ReadLatency; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                err_pipe[i] <= err_pipe[i-1];
                rd_pipe[i]  <= rd_pipe[i-1];
            end
        end
    end

    assign bus.rsp_valid = vld_pipe[ReadLatency];
    assign bus.rsp_err   = err_pipe[ReadLatency];
    assign bus.rsp_rdata = rd_pipe[ReadLatency];
endmodule
